gpio_port: RTL and testbench

- Parametrised, register-mapped controller for the DE-series 40-pin header GPIO.
- Generalises the fixed SW-to-GPIO wiring to per-pin direction control and atomic set/clear of output pins.
- Adds a 2-FF input synchroniser and per-pin rising/falling edge capture with a maskable interrupt.
- Sits between a simple register bus (driven by a CPU or a SW/KEY front-end) and the GPIO inout bus.

---
 rtl/gpio_port_pkg.sv | 21 ++
 rtl/gpio_port_if.sv | 32 +++
 rtl/gpio_sync_edge.sv | 45 ++++
 rtl/gpio_port.sv | 135 +++++++++++++
 tb/tb_gpio_port.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_port_pkg.sv
// ---------------------------------------------------------------------------
// gpio_port_pkg
// Shared constants for the GPIO header controller: the fixed 8-entry register
// map and the encoding of a direction bit that selects output drive.
// ---------------------------------------------------------------------------
package gpio_port_pkg;

   // Register map (address width is 3 bits, all 8 slots used)
   localparam logic [2:0] ADDR_DATA    = 3'd0;  // rd: synchronised pins, wr: output reg
   localparam logic [2:0] ADDR_DIR     = 3'd1;  // rd/wr: 1 = output
   localparam logic [2:0] ADDR_IMASK   = 3'd2;  // rd/wr: interrupt mask
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;  // rd: captured edges, wr: 1 clears
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;  // rd: output reg, wr: OR-set
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;  // rd: output reg, wr: clear ones
   localparam logic [2:0] ADDR_RISE_EN = 3'd6;  // rd/wr: rising-edge capture enable
   localparam logic [2:0] ADDR_FALL_EN = 3'd7;  // rd/wr: falling-edge capture enable

   // Direction bit value that turns a pin into a driven output
   localparam logic DIR_OUT = 1'b1;

endpackage : gpio_port_pkg

// File: rtl/gpio_port_if.sv
// ---------------------------------------------------------------------------
// gpio_port_if
// Simple register bus between a CPU / SW-KEY front-end (master) and the GPIO
// controller (slave).
//   address   : register select
//   write     : one-cycle write strobe, sampled at the clock edge
//   writedata : write data
//   read      : read strobe; readdata is valid the cycle after
//   readdata  : registered read data (driven by the slave)
// ---------------------------------------------------------------------------
interface gpio_port_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
) ();

   logic [ADDR_W-1:0] address;
   logic              write;
   logic [WIDTH-1:0]  writedata;
   logic              read;
   logic [WIDTH-1:0]  readdata;

   modport master (
      output address, write, writedata, read,
      input  readdata
   );

   modport slave (
      input  address, write, writedata, read,
      output readdata
   );

endinterface : gpio_port_if

// File: rtl/gpio_sync_edge.sv
// ---------------------------------------------------------------------------
// gpio_sync_edge
// Two-flop synchroniser for asynchronous header pins plus a previous-value
// flop for edge detection. Edge outputs are raw (not yet gated by enables).
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset
//   i_pins  : raw pin values
//   o_sync  : synchronised pin values (second synchroniser stage)
//   o_rise  : one-cycle pulse per pin on a 0->1 transition of o_sync
//   o_fall  : one-cycle pulse per pin on a 1->0 transition of o_sync
// ---------------------------------------------------------------------------
module gpio_sync_edge #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_pins,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_prev;

   // NOTE: non-blocking assignments make the three stages shift as a true
   // pipeline; blocking ones would collapse them into a single flop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
      end else begin
         r_s1   <= i_pins;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_sync = r_s2;
   assign o_rise = r_s2 & ~r_prev;
   assign o_fall = ~r_s2 & r_prev;

endmodule : gpio_sync_edge

// File: rtl/gpio_port.sv
// ---------------------------------------------------------------------------
// gpio_port
// Register-mapped controller for the 40-pin header GPIO: per-pin direction,
// atomic set/clear of outputs, synchronised inputs, per-pin rising/falling
// edge capture and a maskable level interrupt.
//   CLOCK_50 : system clock, rising edge
//   Reset    : asynchronous active-high reset
//   bus      : register bus slave (address/write/writedata/read/readdata)
//   GPIO     : header pins, driven where DIR=1, high-Z elsewhere
//   irq      : level interrupt, |(EDGECAP & IMASK)
// ---------------------------------------------------------------------------
module gpio_port
   import gpio_port_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
) (
   input  logic             CLOCK_50,
   input  logic             Reset,
   gpio_port_if.slave       bus,
   inout  wire  [WIDTH-1:0] GPIO,
   output logic             irq
);

   // Register file
   logic [WIDTH-1:0]  r_out;
   logic [WIDTH-1:0]  r_dir;
   logic [WIDTH-1:0]  r_imask;
   logic [WIDTH-1:0]  r_edgecap;
   logic [WIDTH-1:0]  r_rise_en;
   logic [WIDTH-1:0]  r_fall_en;
   logic [WIDTH-1:0]  r_readdata;

   // Combinational helpers
   logic [ADDR_W-1:0] w_addr;
   logic [WIDTH-1:0]  w_sync;
   logic [WIDTH-1:0]  w_rise_raw;
   logic [WIDTH-1:0]  w_fall_raw;
   logic [WIDTH-1:0]  w_rise;
   logic [WIDTH-1:0]  w_fall;
   logic [WIDTH-1:0]  w_clr_mask;
   logic [WIDTH-1:0]  w_rd_mux;

   assign w_addr = bus.address;

   // ------------------------------------------------------------------
   // Input synchroniser and raw edge detection
   // ------------------------------------------------------------------
   gpio_sync_edge #(
      .WIDTH (WIDTH)
   ) u_sync_edge (
      .i_clk  (CLOCK_50),
      .i_rst  (Reset),
      .i_pins (GPIO),
      .o_sync (w_sync),
      .o_rise (w_rise_raw),
      .o_fall (w_fall_raw)
   );

   // Enables are zero out of reset, which masks the s2/prev mismatch that
   // appears when pins are already high at reset release.
   assign w_rise = w_rise_raw & r_rise_en;
   assign w_fall = w_fall_raw & r_fall_en;

   // Write-1-to-clear mask for EDGECAP, only during an EDGECAP write
   assign w_clr_mask = (bus.write && (w_addr == ADDR_EDGECAP)) ? bus.writedata : '0;

   // ------------------------------------------------------------------
   // Tri-state drive: pins release as soon as DIR clears (including the
   // asynchronous reset), without waiting for a clock edge.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign GPIO[i] = (r_dir[i] == DIR_OUT) ? r_out[i] : 1'bz;
   end

   // ------------------------------------------------------------------
   // Read mux: built from current register values, so a read and write to
   // the same address in one cycle returns the pre-write contents.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: a default before the case guarantees every path assigns the
      // output, so no latch is inferred.
      w_rd_mux = '0;
      case (w_addr)
         ADDR_DATA:    w_rd_mux = w_sync;
         ADDR_DIR:     w_rd_mux = r_dir;
         ADDR_IMASK:   w_rd_mux = r_imask;
         ADDR_EDGECAP: w_rd_mux = r_edgecap;
         ADDR_OUTSET:  w_rd_mux = r_out;
         ADDR_OUTCLR:  w_rd_mux = r_out;
         ADDR_RISE_EN: w_rd_mux = r_rise_en;
         ADDR_FALL_EN: w_rd_mux = r_fall_en;
         default:      w_rd_mux = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Register file, edge capture and registered read data
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         r_out      <= '0;
         r_dir      <= '0;
         r_imask    <= '0;
         r_edgecap  <= '0;
         r_rise_en  <= '0;
         r_fall_en  <= '0;
         r_readdata <= '0;
      end else begin
         if (bus.write) begin
            case (w_addr)
               ADDR_DATA:    r_out     <= bus.writedata;
               ADDR_DIR:     r_dir     <= bus.writedata;
               ADDR_IMASK:   r_imask   <= bus.writedata;
               ADDR_OUTSET:  r_out     <= r_out | bus.writedata;
               ADDR_OUTCLR:  r_out     <= r_out & ~bus.writedata;
               ADDR_RISE_EN: r_rise_en <= bus.writedata;
               ADDR_FALL_EN: r_fall_en <= bus.writedata;
               default:      ;  // EDGECAP handled below via w_clr_mask
            endcase
         end

         // Clear is applied first so a coincident new edge keeps the bit set
         r_edgecap <= (r_edgecap & ~w_clr_mask) | w_rise | w_fall;

         if (bus.read) begin
            r_readdata <= w_rd_mux;
         end
      end
   end

   assign bus.readdata = r_readdata;
   assign irq          = |(r_edgecap & r_imask);

endmodule : gpio_port

// File: tb/tb_gpio_port.sv
// ---------------------------------------------------------------------------
// tb_gpio_port
// Self-checking bench for gpio_port. Reads push their expected value onto a
// scoreboard queue when issued and are popped and compared once readdata is
// valid. Pin-level and irq checks are made directly against bench constants.
// ---------------------------------------------------------------------------
module tb_gpio_port;
   import gpio_port_pkg::*;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 3;

   logic             clk;
   logic             rst;
   logic             irq;
   wire  [WIDTH-1:0] gpio;

   // External pin driver, per bit
   logic [WIDTH-1:0] tb_en;
   logic [WIDTH-1:0] tb_val;

   for (genvar i = 0; i < WIDTH; i++) begin : g_drv
      assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   gpio_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   gpio_port #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .CLOCK_50 (clk),
      .Reset    (rst),
      .bus      (bus),
      .GPIO     (gpio),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   logic [WIDTH-1:0] exp_q[$];
   string            tag_q[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_pop();
      logic [WIDTH-1:0] e;
      string            t;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, bus.readdata, e);
      end
   endtask

   // Write: strobe sampled at the posedge between the two negedges
   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      bus.address   = a;
      bus.writedata = d;
      bus.write     = 1'b1;
      @(negedge clk);
      bus.write     = 1'b0;
   endtask

   // Read: expectation queued at issue, compared one cycle later
   task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp,
                           input string tag);
      @(negedge clk);
      bus.address = a;
      bus.read    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      bus.read    = 1'b0;
      sb_pop();
   endtask

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.address   = '0;
      bus.write     = 1'b0;
      bus.writedata = '0;
      bus.read      = 1'b0;
      tb_en         = '1;
      tb_val        = 32'hFFFF_0000;
      rst           = 1'b1;

      // ---------------- Reset with pins driven externally ----------------
      repeat (3) @(negedge clk);
      check("rst_pins_hiz", gpio, 32'hFFFF_0000);
      check("rst_readdata", bus.readdata, '0);
      check("rst_irq", {31'd0, irq}, '0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(ADDR_EDGECAP, 32'h0, "rst_no_spurious_cap");
      bus_read(ADDR_DATA, 32'hFFFF_0000, "rst_data_sync");

      // ---------------- Direction and output drive ----------------
      tb_en  = 32'hFFFF_FF00;
      tb_val = 32'hC3A5_5A00;
      bus_write(ADDR_DIR, 32'h0000_00FF);
      check("dir_low_byte_zero", gpio, 32'hC3A5_5A00);
      bus_write(ADDR_DATA, 32'h0000_00A5);
      check("data_drive", gpio, 32'hC3A5_5AA5);
      repeat (2) @(negedge clk);
      bus_read(ADDR_DATA, 32'hC3A5_5AA5, "data_readback");

      // ---------------- Atomic set / clear ----------------
      bus_write(ADDR_OUTSET, 32'h0000_0100);
      bus_write(ADDR_OUTCLR, 32'h0000_0001);
      check("setclr_pins", gpio, 32'hC3A5_5AA4);
      bus_read(ADDR_OUTSET, 32'h0000_01A4, "outset_read");
      bus_read(ADDR_OUTCLR, 32'h0000_01A4, "outclr_read");
      bus_read(ADDR_DIR, 32'h0000_00FF, "dir_read");

      // ---------------- Rising edge capture and irq timing ----------------
      bus_write(ADDR_DIR, 32'h0);
      tb_en  = '1;
      tb_val = '0;
      bus_write(ADDR_RISE_EN, 32'h1);
      bus_write(ADDR_IMASK, 32'h1);
      repeat (4) @(negedge clk);
      bus_read(ADDR_EDGECAP, 32'h0, "cap_idle");
      check("irq_idle", {31'd0, irq}, '0);

      @(negedge clk);
      tb_val[0] = 1'b1;                 // settles before edge k
      @(negedge clk);
      check("irq_edge1", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_edge2", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_edge3", {31'd0, irq}, 32'd1);
      bus_read(ADDR_EDGECAP, 32'h1, "cap_rise");

      tb_val[0] = 1'b0;                 // falling edge, FALL_EN = 0
      repeat (4) @(negedge clk);
      bus_read(ADDR_EDGECAP, 32'h1, "cap_fall_ignored_hold");

      // ---------------- Clear racing a new edge ----------------
      @(negedge clk);
      tb_val[0] = 1'b1;                 // before edge k; capture at k+2
      @(negedge clk);
      bus_write(ADDR_EDGECAP, 32'h1);   // strobe sampled at edge k+2
      bus_read(ADDR_EDGECAP, 32'h1, "cap_edge_wins_clear");
      bus_write(ADDR_EDGECAP, 32'h1);
      bus_read(ADDR_EDGECAP, 32'h0, "cap_cleared");
      check("irq_cleared", {31'd0, irq}, '0);

      tb_val[0] = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(ADDR_EDGECAP, 32'h0, "cap_fall_ignored");

      // ---------------- Falling edge capture and mask ----------------
      bus_write(ADDR_FALL_EN, 32'h2);
      tb_val[1] = 1'b1;
      repeat (4) @(negedge clk);
      tb_val[1] = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(ADDR_EDGECAP, 32'h2, "cap_fall");
      check("irq_masked", {31'd0, irq}, '0);
      bus_write(ADDR_IMASK, 32'h3);
      check("irq_unmasked", {31'd0, irq}, 32'd1);
      bus_read(ADDR_IMASK, 32'h3, "imask_read");
      bus_read(ADDR_RISE_EN, 32'h1, "rise_en_read");
      bus_read(ADDR_FALL_EN, 32'h2, "fall_en_read");

      // ---------------- Simultaneous read and write ----------------
      tb_en = '0;
      @(negedge clk);
      bus.address   = ADDR_DIR;
      bus.writedata = 32'h0000_F00F;
      bus.write     = 1'b1;
      bus.read      = 1'b1;
      exp_q.push_back(32'h0);
      tag_q.push_back("rw_same_addr_prewrite");
      @(negedge clk);
      bus.write = 1'b0;
      bus.read  = 1'b0;
      sb_pop();
      bus_read(ADDR_DIR, 32'h0000_F00F, "rw_same_addr_after");

      // ---------------- Asynchronous reset mid-drive ----------------
      bus_write(ADDR_DIR, 32'hFFFF_FFFF);
      bus_write(ADDR_DATA, 32'hFFFF_FFFF);
      check("drive_all", gpio, 32'hFFFF_FFFF);
      check("irq_pre_rst", {31'd0, irq}, 32'd1);
      repeat (2) @(negedge clk);
      bus_read(ADDR_DATA, 32'hFFFF_FFFF, "data_all_ones");

      @(posedge clk);
      #2;
      rst    = 1'b1;
      tb_val = '0;
      tb_en  = '1;
      #1;
      check("async_rst_pins_release", gpio, 32'h0);
      check("async_rst_readdata", bus.readdata, '0);
      check("async_rst_irq", {31'd0, irq}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus_read(ADDR_W'(i), 32'h0, $sformatf("post_rst_addr%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_gpio_port
